// File: rtl/jpd_scan_ctrl_pkg.sv
// Shared definitions for the SNES-style joypad scanner: FSM states, raw/vector
// bit positions, presence signature and the raw-to-candidate decode.
package jpd_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    JPD_ST_IDLE   = 2'd0,
    JPD_ST_LATCH  = 2'd1,
    JPD_ST_SHIFT  = 2'd2,
    JPD_ST_UPDATE = 2'd3
  } jpd_state_e;

  // Raw serial bit positions as shifted out by the pad (L/R at 10/11 are unused).
  localparam int JPD_RAW_B     = 0;
  localparam int JPD_RAW_Y     = 1;
  localparam int JPD_RAW_SEL   = 2;
  localparam int JPD_RAW_START = 3;
  localparam int JPD_RAW_UP    = 4;
  localparam int JPD_RAW_DN    = 5;
  localparam int JPD_RAW_LT    = 6;
  localparam int JPD_RAW_RT    = 7;
  localparam int JPD_RAW_A     = 8;
  localparam int JPD_RAW_X     = 9;
  localparam int JPD_RAW_SIG   = 12;

  // Vector order {up,down,left,right,b,a,tb,ta,select,start}, MSB first.
  localparam int JPD_VEC_START  = 0;
  localparam int JPD_VEC_SELECT = 1;
  localparam int JPD_VEC_TA     = 2;
  localparam int JPD_VEC_TB     = 3;
  localparam int JPD_VEC_A      = 4;
  localparam int JPD_VEC_B      = 5;
  localparam int JPD_VEC_RIGHT  = 6;
  localparam int JPD_VEC_LEFT   = 7;
  localparam int JPD_VEC_DOWN   = 8;
  localparam int JPD_VEC_UP     = 9;

  localparam logic [3:0] JPD_SIGNATURE = 4'hF;

  typedef struct packed {
    logic       present;
    logic [9:0] vec;
  } jpd_cand_t;

  // An absent pad (signature mismatch) always decodes to the all-zero candidate.
  function automatic jpd_cand_t jpd_decode(input logic [15:0] raw);
    jpd_cand_t c;
    c = '0;
    if (raw[JPD_RAW_SIG +: 4] == JPD_SIGNATURE) begin
      c.present               = 1'b1;
      c.vec[JPD_VEC_UP]       = ~raw[JPD_RAW_UP];
      c.vec[JPD_VEC_DOWN]     = ~raw[JPD_RAW_DN];
      c.vec[JPD_VEC_LEFT]     = ~raw[JPD_RAW_LT];
      c.vec[JPD_VEC_RIGHT]    = ~raw[JPD_RAW_RT];
      c.vec[JPD_VEC_B]        = ~raw[JPD_RAW_B];
      c.vec[JPD_VEC_A]        = ~raw[JPD_RAW_A];
      c.vec[JPD_VEC_TB]       = ~raw[JPD_RAW_Y];
      c.vec[JPD_VEC_TA]       = ~raw[JPD_RAW_X];
      c.vec[JPD_VEC_SELECT]   = ~raw[JPD_RAW_SEL];
      c.vec[JPD_VEC_START]    = ~raw[JPD_RAW_START];
    end
    return c;
  endfunction

endpackage

// File: rtl/jpd_sync2.sv
// Two-flop synchronizer for an asynchronous pad data line; resets to the
// idle/released level (1).
module jpd_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/jpd_scan_ctrl.sv
// Periodic scanner for two serial gamepads on a shared latch/clock pair, with
// two-scan agreement filtering of the per-player button vectors.
module jpd_scan_ctrl
  import jpd_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV  = 300,
  parameter int SCAN_DIV = 833333
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scan_en,
  input  logic       i_pad1_data,
  input  logic       i_pad2_data,
  output logic       o_pad_latch,
  output logic       o_pad_clk,
  output logic [9:0] o_jpd_1p,
  output logic [9:0] o_jpd_2p,
  output logic       o_1p_present,
  output logic       o_2p_present,
  output logic       o_scan_done
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int HW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(CLK_DIV - 1);

  logic pad1_sync;
  logic pad2_sync;

  jpd_sync2 u_sync_pad1 (.clk(i_clk), .rst(i_rst), .d(i_pad1_data), .q(pad1_sync));
  jpd_sync2 u_sync_pad2 (.clk(i_clk), .rst(i_rst), .d(i_pad2_data), .q(pad2_sync));

  jpd_state_e    state;
  logic [TW-1:0] timer;
  logic [HW-1:0] half_cnt;
  logic          second_half;
  logic [3:0]    slot;
  logic [15:0]   raw1;
  logic [15:0]   raw2;
  jpd_cand_t     prev1;
  jpd_cand_t     prev2;
  jpd_cand_t     cand1;
  jpd_cand_t     cand2;
  logic          tick;

  assign tick  = (timer == TIMER_LAST);
  assign cand1 = jpd_decode(raw1);
  assign cand2 = jpd_decode(raw2);

  // Free-running period timer, independent of the FSM and of i_scan_en.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timer <= '0;
    end else begin
      timer <= tick ? '0 : timer + TW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= JPD_ST_IDLE;
      half_cnt     <= '0;
      second_half  <= 1'b0;
      slot         <= '0;
      raw1         <= '0;
      raw2         <= '0;
      prev1        <= '0;
      prev2        <= '0;
      o_pad_latch  <= 1'b0;
      o_pad_clk    <= 1'b1;
      o_jpd_1p     <= '0;
      o_jpd_2p     <= '0;
      o_1p_present <= 1'b0;
      o_2p_present <= 1'b0;
      o_scan_done  <= 1'b0;
    end else begin
      case (state)
        JPD_ST_IDLE: begin
          if (tick && i_scan_en) begin
            state       <= JPD_ST_LATCH;
            o_pad_latch <= 1'b1;
            half_cnt    <= '0;
            second_half <= 1'b0;
          end
        end
        JPD_ST_LATCH: begin
          // Latch pulse spans two half periods with the shift clock held high.
          if (half_cnt == HALF_LAST) begin
            half_cnt    <= '0;
            second_half <= ~second_half;
            if (second_half) begin
              state       <= JPD_ST_SHIFT;
              o_pad_latch <= 1'b0;
              slot        <= '0;
            end
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end
        JPD_ST_SHIFT: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt    <= '0;
            second_half <= ~second_half;
            if (!second_half) begin
              // Sample at the end of the high half; bit k ends up in raw[k].
              raw1      <= {pad1_sync, raw1[15:1]};
              raw2      <= {pad2_sync, raw2[15:1]};
              o_pad_clk <= 1'b0;
            end else begin
              o_pad_clk <= 1'b1;
              if (slot == 4'd15) begin
                state       <= JPD_ST_UPDATE;
                o_scan_done <= 1'b1;
              end else begin
                slot <= slot + 4'd1;
              end
            end
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end
        JPD_ST_UPDATE: begin
          state       <= JPD_ST_IDLE;
          o_scan_done <= 1'b0;
          // Commit only when two consecutive scans agree; history always advances.
          if (cand1 == prev1) {o_1p_present, o_jpd_1p} <= cand1;
          if (cand2 == prev2) {o_2p_present, o_jpd_2p} <= cand2;
          prev1 <= cand1;
          prev2 <= cand2;
        end
        default: state <= JPD_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpd_scan_ctrl.sv
// Bench for jpd_scan_ctrl: serial pad model, scan-level reference filter and
// per-scenario checks of timing, filtering, reset abort and scan enable.
`timescale 1ns/1ps
module tb_jpd_scan_ctrl;

  localparam int CLK_DIV  = 4;
  localparam int SCAN_DIV = 200;
  localparam int SCAN_LEN = 34 * CLK_DIV + 1;
  localparam int WAIT_MAX = SCAN_DIV + SCAN_LEN + 20;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_scan_en = 1'b0;
  logic       i_pad1_data;
  logic       i_pad2_data;
  logic       o_pad_latch;
  logic       o_pad_clk;
  logic [9:0] o_jpd_1p;
  logic [9:0] o_jpd_2p;
  logic       o_1p_present;
  logic       o_2p_present;
  logic       o_scan_done;

  int total = 0;
  int bad   = 0;

  jpd_scan_ctrl #(.CLK_DIV(CLK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_scan_en(i_scan_en),
    .i_pad1_data(i_pad1_data), .i_pad2_data(i_pad2_data),
    .o_pad_latch(o_pad_latch), .o_pad_clk(o_pad_clk),
    .o_jpd_1p(o_jpd_1p), .o_jpd_2p(o_jpd_2p),
    .o_1p_present(o_1p_present), .o_2p_present(o_2p_present),
    .o_scan_done(o_scan_done)
  );

  always #5 i_clk = ~i_clk;

  // Pad model: latch loads the word and presents bit 0; each rising shift clock
  // advances one bit. An absent pad holds its data line low.
  logic [15:0] next1 = 16'hFFFF, next2 = 16'hFFFF;
  logic [15:0] word1 = 16'hFFFF, word2 = 16'hFFFF;
  bit          absent_next1 = 1'b0, absent_next2 = 1'b0;
  bit          absent1 = 1'b0, absent2 = 1'b0;
  int          idx = 0;

  always @(posedge o_pad_clk or posedge o_pad_latch) begin
    if (o_pad_latch) begin
      idx     = 0;
      word1   = next1;
      word2   = next2;
      absent1 = absent_next1;
      absent2 = absent_next2;
    end else begin
      idx = idx + 1;
    end
  end

  assign i_pad1_data = absent1 ? 1'b0 : ((idx < 16) ? word1[idx[3:0]] : 1'b1);
  assign i_pad2_data = absent2 ? 1'b0 : ((idx < 16) ? word2[idx[3:0]] : 1'b1);

  // Reference filter: {present, vector} per pad, one step per completed scan.
  logic [10:0] prev_m1 = '0, prev_m2 = '0, out_m1 = '0, out_m2 = '0;

  function automatic logic [10:0] ref_cand(input logic [15:0] raw);
    int         src [10] = '{4, 5, 6, 7, 0, 8, 1, 9, 2, 3};
    logic [9:0] v;
    if (raw[15:12] != 4'hF) return 11'd0;
    for (int i = 0; i < 10; i++) v[9 - i] = ~raw[src[i]];
    return {1'b1, v};
  endfunction

  task automatic ref_scan(input logic [15:0] r1, input logic [15:0] r2);
    logic [10:0] c1, c2;
    c1 = ref_cand(r1);
    c2 = ref_cand(r2);
    if (c1 == prev_m1) out_m1 = c1;
    if (c2 == prev_m2) out_m2 = c2;
    prev_m1 = c1;
    prev_m2 = c2;
  endtask

  task automatic wait_done(input int limit, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      @(negedge i_clk);
      n++;
      if (o_scan_done) seen = 1'b1;
    end
  endtask

  // Load the pads, run one scan to completion and step the model; outputs are
  // committed one cycle after the done pulse.
  task automatic do_scan(input logic [15:0] r1, input bit a1,
                         input logic [15:0] r2, input bit a2, output bit seen);
    int n;
    next1 = r1; absent_next1 = a1;
    next2 = r2; absent_next2 = a2;
    wait_done(WAIT_MAX, n, seen);
    if (seen) ref_scan(a1 ? 16'h0000 : r1, a2 ? 16'h0000 : r2);
    @(negedge i_clk);
  endtask

  task automatic test_reset;
    i_scan_en    = 1'b1;
    next1        = 16'hFFFE;
    absent_next1 = 1'b0;
    next2        = 16'hFFFF;
    absent_next2 = 1'b1;
    #1 i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    total++; if (o_pad_latch !== 1'b0) begin bad++; $display("FAIL reset_latch got=%b exp=0", o_pad_latch); end
    total++; if (o_pad_clk !== 1'b1) begin bad++; $display("FAIL reset_pad_clk got=%b exp=1", o_pad_clk); end
    total++; if (o_jpd_1p !== 10'h000 || o_jpd_2p !== 10'h000) begin bad++; $display("FAIL reset_vec got=%h/%h exp=000/000", o_jpd_1p, o_jpd_2p); end
    total++; if (o_1p_present !== 1'b0 || o_2p_present !== 1'b0) begin bad++; $display("FAIL reset_present got=%b%b exp=00", o_1p_present, o_2p_present); end
    total++; if (o_scan_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", o_scan_done); end
    i_rst = 1'b0;
  endtask

  task automatic test_first_scan;
    int  latch_rise = -1, latch_cnt = 0, low_run = 0, low_pulses = 0;
    int  width_bad = 0, overlap = 0, done_n = -1;
    for (int n = 1; n <= 2 * SCAN_DIV + 50 && done_n < 0; n++) begin
      @(negedge i_clk);
      if (o_pad_latch) begin
        if (latch_rise < 0) latch_rise = n;
        latch_cnt++;
        if (!o_pad_clk) overlap++;
      end
      if (!o_pad_clk) low_run++;
      else if (low_run > 0) begin
        low_pulses++;
        if (low_run != 2 * CLK_DIV / 2) width_bad++;
        low_run = 0;
      end
      if (o_scan_done) done_n = n;
    end
    total++; if (latch_rise !== SCAN_DIV) begin bad++; $display("FAIL first_tick latch_rise=%0d exp=%0d", latch_rise, SCAN_DIV); end
    total++; if (latch_cnt !== 2 * CLK_DIV) begin bad++; $display("FAIL latch_width got=%0d exp=%0d", latch_cnt, 2 * CLK_DIV); end
    total++; if (overlap !== 0) begin bad++; $display("FAIL latch_clk_low got=%0d exp=0", overlap); end
    total++; if (low_pulses !== 16 || width_bad !== 0) begin bad++; $display("FAIL clk_pulses got=%0d badwidth=%0d exp=16/0", low_pulses, width_bad); end
    total++; if (done_n - (latch_rise - 1) !== SCAN_LEN) begin bad++; $display("FAIL scan_len got=%0d exp=%0d", done_n - (latch_rise - 1), SCAN_LEN); end
    if (done_n > 0) ref_scan(16'hFFFE, 16'h0000);
    @(negedge i_clk);
    total++; if (o_scan_done !== 1'b0) begin bad++; $display("FAIL done_width got=%b exp=0", o_scan_done); end
    total++; if ({o_1p_present, o_jpd_1p} !== out_m1 || out_m1 !== 11'd0) begin bad++; $display("FAIL first_scan_1p got=%b/%h exp=0/000", o_1p_present, o_jpd_1p); end
    total++; if ({o_2p_present, o_jpd_2p} !== 11'd0) begin bad++; $display("FAIL first_scan_2p got=%b/%h exp=0/000", o_2p_present, o_jpd_2p); end
  endtask

  task automatic test_two_scan_agree;
    bit seen;
    do_scan(16'hFFFE, 1'b0, 16'hFFFF, 1'b1, seen);
    total++; if (!seen) begin bad++; $display("FAIL agree_timeout got=none exp=done"); end
    total++; if (o_jpd_1p !== 10'h020 || o_1p_present !== 1'b1) begin bad++; $display("FAIL agree_1p got=%b/%h exp=1/020", o_1p_present, o_jpd_1p); end
    total++; if (o_jpd_2p !== 10'h000 || o_2p_present !== 1'b0) begin bad++; $display("FAIL absent_2p got=%b/%h exp=0/000", o_2p_present, o_jpd_2p); end
  endtask

  task automatic test_bounce;
    bit seen;
    for (int i = 0; i < 4; i++) begin
      do_scan((i % 2 == 0) ? 16'hFFF7 : 16'hFFFF, 1'b0, 16'hFFFF, 1'b1, seen);
      total++; if (!seen) begin bad++; $display("FAIL bounce_timeout scan=%0d", i); end
      total++; if (o_jpd_1p[0] !== 1'b0) begin bad++; $display("FAIL bounce_start scan=%0d got=%b exp=0", i, o_jpd_1p[0]); end
      total++; if ({o_1p_present, o_jpd_1p} !== out_m1) begin bad++; $display("FAIL bounce_1p scan=%0d got=%b/%h exp=%b/%h", i, o_1p_present, o_jpd_1p, out_m1[10], out_m1[9:0]); end
    end
  endtask

  task automatic test_random;
    bit          seen, a1, a2;
    logic [15:0] r1 = 16'hFFFF, r2 = 16'hFFFF;
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0: a1 = 1'b1;
        1: a1 = 1'b0;
        2: begin a1 = 1'b0; r1 = {4'hF, 12'($urandom)}; end
        default: begin a1 = 1'b0; r1 = 16'($urandom); end
      endcase
      case ($urandom_range(0, 3))
        0: a2 = 1'b1;
        1: a2 = 1'b0;
        2: begin a2 = 1'b0; r2 = {4'hF, 12'($urandom)}; end
        default: begin a2 = 1'b0; r2 = 16'($urandom); end
      endcase
      do_scan(r1, a1, r2, a2, seen);
      total++; if (!seen) begin bad++; $display("FAIL random_timeout scan=%0d", i); end
      total++; if ({o_1p_present, o_jpd_1p} !== out_m1) begin bad++; $display("FAIL random_1p scan=%0d raw=%h got=%b/%h exp=%b/%h", i, r1, o_1p_present, o_jpd_1p, out_m1[10], out_m1[9:0]); end
      total++; if ({o_2p_present, o_jpd_2p} !== out_m2) begin bad++; $display("FAIL random_2p scan=%0d raw=%h got=%b/%h exp=%b/%h", i, r2, o_2p_present, o_jpd_2p, out_m2[10], out_m2[9:0]); end
    end
  endtask

  task automatic test_reset_mid_scan;
    int  falls = 0, n, first_latch = -1;
    bit  prev_clk = 1'b1, seen;
    next1 = 16'hFFEF; absent_next1 = 1'b0;
    next2 = 16'hFFFD; absent_next2 = 1'b0;
    for (int i = 0; i < 2 * WAIT_MAX && falls < 8; i++) begin
      @(negedge i_clk);
      if (prev_clk && !o_pad_clk) falls++;
      prev_clk = o_pad_clk;
    end
    total++; if (falls !== 8) begin bad++; $display("FAIL rst_slot7_reach got=%0d exp=8", falls); end
    #2 i_rst = 1'b1;
    #1;
    total++; if (o_pad_clk !== 1'b1 || o_pad_latch !== 1'b0) begin bad++; $display("FAIL rst_mid_pins got=clk%b/latch%b exp=1/0", o_pad_clk, o_pad_latch); end
    total++; if (o_jpd_1p !== 10'h000 || o_jpd_2p !== 10'h000 || o_1p_present !== 1'b0 || o_2p_present !== 1'b0) begin bad++; $display("FAIL rst_mid_out got=%h/%h exp=000/000", o_jpd_1p, o_jpd_2p); end
    prev_m1 = '0; prev_m2 = '0; out_m1 = '0; out_m2 = '0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < WAIT_MAX + SCAN_DIV) begin
      @(negedge i_clk);
      n++;
      if (o_pad_latch && first_latch < 0) first_latch = n;
      if (o_scan_done) seen = 1'b1;
    end
    total++; if (first_latch !== SCAN_DIV) begin bad++; $display("FAIL rst_next_tick got=%0d exp=%0d", first_latch, SCAN_DIV); end
    total++; if (!seen || n !== SCAN_DIV - 1 + SCAN_LEN) begin bad++; $display("FAIL rst_no_early_done got=%0d exp=%0d", n, SCAN_DIV - 1 + SCAN_LEN); end
    if (seen) ref_scan(16'hFFEF, 16'hFFFD);
    @(negedge i_clk);
    total++; if ({o_1p_present, o_jpd_1p} !== out_m1 || {o_2p_present, o_jpd_2p} !== out_m2) begin bad++; $display("FAIL rst_after_scan got=%h/%h exp=%h/%h", o_jpd_1p, o_jpd_2p, out_m1[9:0], out_m2[9:0]); end
  endtask

  task automatic test_scan_en_off;
    int  n, latches = 0, dones = 0;
    bit  seen, in_shift = 1'b0, was_latch = 1'b0;
    next1 = 16'hFFEF; absent_next1 = 1'b0;
    next2 = 16'hFFFD; absent_next2 = 1'b0;
    for (int i = 0; i < 2 * WAIT_MAX && !in_shift; i++) begin
      @(negedge i_clk);
      if (was_latch && !o_pad_latch) in_shift = 1'b1;
      was_latch = o_pad_latch;
    end
    repeat (20) @(negedge i_clk);
    i_scan_en = 1'b0;
    wait_done(WAIT_MAX, n, seen);
    total++; if (!seen) begin bad++; $display("FAIL en_off_done got=none exp=done"); end
    if (seen) ref_scan(16'hFFEF, 16'hFFFD);
    @(negedge i_clk);
    total++; if ({o_1p_present, o_jpd_1p} !== out_m1 || {o_2p_present, o_jpd_2p} !== out_m2) begin bad++; $display("FAIL en_off_commit got=%b%h/%b%h exp=%h/%h", o_1p_present, o_jpd_1p, o_2p_present, o_jpd_2p, out_m1, out_m2); end
    for (int i = 0; i < 3 * SCAN_DIV; i++) begin
      @(negedge i_clk);
      if (o_pad_latch) latches++;
      if (o_scan_done) dones++;
    end
    total++; if (latches !== 0 || dones !== 0) begin bad++; $display("FAIL en_off_idle got=latch%0d/done%0d exp=0/0", latches, dones); end
  endtask

  initial begin
    test_reset;
    test_first_scan;
    test_two_scan_agree;
    test_bounce;
    test_random;
    test_reset_mid_scan;
    test_scan_en_off;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
